xnor_cmp_sched: RTL
===================

// Module: xnor_cmp_sched
// PURPOSE
//  - Shares one registered bitwise-XNOR compare datapath (y = ~(a^b)) among NUM_REQ requesters.
//  - Round-robin arbitration; each requester submits one operand pair per valid/ready transfer.
//  - Result is returned with the winner's ID on a single valid/ready output port.
//  - Sits between operand producers (pattern checkers, BIST lanes) and a result consumer.
// PARAMETERS
//  WIDTH    4  operand width in bits (>=1)
//  NUM_REQ  4  number of requesters (>=1)
//  ID_W     $clog2(NUM_REQ) or 1 if NUM_REQ==1; width of requester ID
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  req_valid  in   NUM_REQ        per-requester operand valid
//  req_ready  out  NUM_REQ        per-requester accept; one-hot or zero
//  req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B, same packing
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accept
//  out_y      out  WIDTH          ~(a^b) of the granted pair
//  out_match  out  1              &out_y: all bits equal
//  out_id     out  ID_W           index of requester that produced the result
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_y=0, out_match=0, out_id=0, rr_ptr=0, state=S_IDLE.
//    Any pending result is dropped; req_ready=0 while in reset.
//  - FSM: S_IDLE (output register empty) / S_HOLD (result waiting).
//    S_IDLE -> S_HOLD on transfer.
//    S_HOLD -> S_IDLE on out_ready with no new transfer.
//    S_HOLD -> S_HOLD on out_ready with a new transfer.
//  - can_accept = (state==S_IDLE) | out_ready.
//    Throughput: one result per cycle when out_ready is held high.
//  - Grant: if can_accept, winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//    req_ready[winner]=1, all others 0. req_ready is combinational from req_valid, state, out_ready and rr_ptr.
//  - Transfer: req_valid[i] & req_ready[i]. On the next edge:
//    out_y <= ~(req_a[i]^req_b[i]); out_match <= &that; out_id <= i; out_valid <= 1;
//    rr_ptr <= (i==NUM_REQ-1) ? 0 : i+1.
//  - Latency: exactly 1 cycle from transfer edge to out_valid=1.
//  - Hold: while out_valid & !out_ready, out_y/out_match/out_id are stable and all req_ready=0.
//  - Pop with no transfer: out_valid <= 0. Data regs keep their last value.
//  - Requester may drop req_valid without a transfer; no state change. rr_ptr moves only on a transfer.
//  - NUM_REQ==1: rr_ptr is constant 0; out_id is 0.
//  - No combinational path from req_a/req_b to any output.
// CONFIGURATION
//  - Macro XNOR_CMP_SCHED_STATS_EN. When defined, adds two outputs:
//    stat_xfers [15:0]: transfers since reset;
//    stat_miss  [15:0]: transfers with match==0.
//    Both reset to 0 and saturate at 16'hFFFF.
//    Both update on the transfer edge, using the match value computed that cycle.
//  - Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package xnor_cmp_pkg:
//    state enum {S_IDLE, S_HOLD};
//    localparam STAT_W=16;
//    function rr_next(idx, n) for pointer wrap.
//  - Sub-module xnor_rr_arbiter (NUM_REQ): inputs req, ptr, en; outputs gnt one-hot and gnt_id.
//    Purely combinational.
//  - Top holds the FSM, output register, rr_ptr and the optional stats counters.
// TESTING (WIDTH=4, NUM_REQ=4)
//  1. Reset with random inputs -> out_valid=0, out_y=0, out_match=0, out_id=0, req_ready=0.
//  2. req0 a=0101 b=0101, out_ready=1 -> next cycle out_valid=1, out_y=1111, out_match=1, out_id=0.
//  3. req2 a=0011 b=0101 -> out_y=1001, out_match=0, out_id=2; rr_ptr then 3.
//  4. All four req_valid=1, out_ready=1 for 5 cycles -> out_id sequence 0,1,2,3,0 on consecutive cycles.
//  5. out_valid=1 and out_ready=0 for 3 cycles with req1 pending -> outputs stable, req_ready=0000;
//     raise out_ready -> req_ready=0010 that cycle, new result next cycle.
//  6. rst_n low mid-S_HOLD -> out_valid drops without a clock edge; after release, req3|req0 pending -> out_id=0.
//     With XNOR_CMP_SCHED_STATS_EN: 3 transfers (1 mismatch) -> stat_xfers=3, stat_miss=1.

Source files
------------

// File: rtl/xnor_cmp_pkg.sv
// Shared types and helpers for the xnor_cmp_sched compare scheduler.
package xnor_cmp_pkg;

  // Output register state: empty, or holding a result for the consumer.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam int STAT_W = 16;

  // Round-robin pointer successor with wrap at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/xnor_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// found when searching ptr, ptr+1, ... (mod NUM_REQ). No grant when en=0.
module xnor_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int   idx;
  logic found;

  // Rotating priority search starting at ptr; first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(ptr) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/xnor_cmp_sched.sv
// Shares one registered XNOR compare datapath among NUM_REQ requesters
// with round-robin arbitration and a single valid/ready result port.
// Optional statistics counters: define XNOR_CMP_SCHED_STATS_EN.
//
// Handshake: a transfer happens on any edge where valid and ready are both
// high on the same port; valid never depends on ready of the same port,
// and req_ready is one-hot or zero.
module xnor_cmp_sched
  import xnor_cmp_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic                     out_match,
  output logic [ID_W-1:0]          out_id,
  output state_e                   dbg_state
`ifdef XNOR_CMP_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_xfers,
  output logic [STAT_W-1:0]        stat_miss
`endif
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               match_q, match_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               can_accept;
  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;
  logic [WIDTH-1:0]   sel_a, sel_b, y_new;

  // Accept when the output register is empty or is being drained this cycle;
  // reset also masks the grant so req_ready stays low during reset.
  assign can_accept = (state_q == S_IDLE) | out_ready;
  assign arb_en     = can_accept & rst_n;

  xnor_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant is only issued on a valid request, so any grant is a transfer.
  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_a     = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b     = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign y_new     = ~(sel_a ^ sel_b);

  // Next-state, result capture and pointer advance.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    y_d      = y_q;
    match_d  = match_q;
    id_d     = id_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_HOLD;
      S_HOLD:  if (out_ready && !xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (xfer) begin
      y_d      = y_new;
      match_d  = &y_new;
      id_d     = gnt_id;
      rr_ptr_d = ID_W'(rr_next(int'(gnt_id), NUM_REQ));
    end
  end

  // State, pointer and output data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      y_q      <= '0;
      match_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      y_q      <= y_d;
      match_q  <= match_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign out_y     = y_q;
  assign out_match = match_q;
  assign out_id    = id_q;
  assign dbg_state = state_q;

`ifdef XNOR_CMP_SCHED_STATS_EN
  logic [STAT_W-1:0] xfers_q, xfers_d;
  logic [STAT_W-1:0] miss_q, miss_d;

  // Saturating transfer and mismatch counters.
  always_comb begin
    xfers_d = xfers_q;
    miss_d  = miss_q;
    if (xfer && (xfers_q != '1)) xfers_d = xfers_q + 1'b1;
    if (xfer && !(&y_new) && (miss_q != '1)) miss_d = miss_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfers_q <= '0;
      miss_q  <= '0;
    end else begin
      xfers_q <= xfers_d;
      miss_q  <= miss_d;
    end
  end

  assign stat_xfers = xfers_q;
  assign stat_miss  = miss_q;
`endif

endmodule
